pht_update_scheduler: RTL and testbench



---
 rtl/pht_update_scheduler_pkg.sv | 52 +++++
 rtl/pht_update_queue.sv | 71 +++++++
 rtl/pht_update_scheduler.sv | 142 ++++++++++++++
 tb/tb_pht_update_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// Types, constants and helpers for the PHT update scheduler. These are the
// FetchUnitTypes additions: branch result and queue entry structs, the PHT
// index hash, the saturating counter update and the arbitration constants.
package pht_update_scheduler_pkg;

  localparam int ADDR_WIDTH          = 32;
  localparam int INSN_ADDR_BIT_WIDTH = 2;
  localparam int PHT_INDEX_WIDTH     = 10;
  localparam int PHT_ENTRY_WIDTH     = 2;
  localparam int PHT_QUEUE_SIZE      = 32;
  localparam int PHT_STARVE_LIMIT    = 8;
  localparam int PHT_FORCE_THRESHOLD = 28;

  typedef logic [ADDR_WIDTH-1:0]      AddrPath;
  typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;
  typedef logic [PHT_INDEX_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic                   isCondBr;
    AddrPath                brAddr;
    BranchGlobalHistoryPath globalHistory;
    logic                   execTaken;
    PHT_EntryPath           phtPrevValue;
  } BranchResult;

  // phtWE is carried for layout compatibility with the PHT write port and is
  // always 1 inside the queue.
  typedef struct packed {
    logic         phtWE;
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
  } PhtQueueEntry;

  // PC bits above the instruction offset, XORed with the global history.
  function automatic PHT_IndexPath ToPHT_Index(AddrPath addr, BranchGlobalHistoryPath hist);
    return addr[INSN_ADDR_BIT_WIDTH +: PHT_INDEX_WIDTH] ^ hist;
  endfunction

  // Saturating 2-bit counter step, done in 3 bits so the +1 cannot wrap.
  function automatic PHT_EntryPath NextPhtValue(PHT_EntryPath prev, logic taken);
    logic [2:0] v;
    if (taken) v = ({1'b0, prev} + 3'd1 > {1'b0, PHT_ENTRY_MAX}) ? {1'b0, PHT_ENTRY_MAX}
                                                                 : {1'b0, prev} + 3'd1;
    else       v = (prev == '0) ? 3'd0 : {1'b0, prev} - 3'd1;
    return PHT_EntryPath'(v);
  endfunction

endpackage

// File: rtl/pht_update_queue.sv
// 2-push / 1-pop circular buffer of PHT updates.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pushA_i/entryA_i    first push, written at the tail
//   pushB_i/entryB_i    second push, written after A (only with pushA_i)
//   pop_i               remove the head entry
//   tailWe_i/tailWv_i   overwrite the value of the newest stored entry
//   head_o, tail_o      oldest / newest stored entries
//   count_o, free_o     occupancy and free slots (before this cycle's ops)
module pht_update_queue
  import pht_update_scheduler_pkg::*;
#(
  parameter  int DEPTH = PHT_QUEUE_SIZE,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushA_i,
  input  PhtQueueEntry  entryA_i,
  input  logic          pushB_i,
  input  PhtQueueEntry  entryB_i,
  input  logic          pop_i,
  input  logic          tailWe_i,
  input  PHT_EntryPath  tailWv_i,
  output PhtQueueEntry  head_o,
  output PhtQueueEntry  tail_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] free_o
);

  localparam logic [AW-1:0] ONE = AW'(1);

  PhtQueueEntry  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, tailPrev, tailNext;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    tailPrev = tail_q - ONE;
    tailNext = tail_q + ONE;
    head_d   = head_q + AW'(pop_i);
    tail_d   = tail_q + AW'(pushA_i) + AW'(pushB_i);
    cnt_d    = cnt_q + CW'(pushA_i) + CW'(pushB_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is live.
  always_ff @(posedge clk) begin
    if (tailWe_i) mem_q[tailPrev].phtWV <= tailWv_i;
    if (pushA_i)  mem_q[tail_q]         <= entryA_i;
    if (pushB_i)  mem_q[tailNext]       <= entryB_i;
  end

  assign head_o  = mem_q[head_q];
  assign tail_o  = mem_q[tailPrev];
  assign count_o = cnt_q;
  assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/pht_update_scheduler.sv
// Sequences commit-time PHT counter updates onto the shared PHT port.
// Takes up to two branch results per cycle, queues the new counters and
// drains one per cycle when fetch is idle, or forcibly (stalling fetch) when
// the queue starves or nears full.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   brResult[2]     commit results, lane 0 older
//   phtReadReq      fetch wants the PHT port
//   fetchStall      fetch read denied this cycle
//   phtWE/WA/WV     PHT write port (combinational from queue state)
//   queueCount      registered occupancy
//   updateDropped   registered pulse: a lane was dropped last cycle
// Optional feature: define PHT_UPDATE_COALESCE_EN to merge same-index
// updates into the newest queued entry instead of pushing.
module pht_update_scheduler
  import pht_update_scheduler_pkg::*;
#(
  parameter  int QUEUE_DEPTH     = PHT_QUEUE_SIZE,
  parameter  int STARVE_LIMIT    = PHT_STARVE_LIMIT,
  parameter  int FORCE_THRESHOLD = PHT_FORCE_THRESHOLD,
  localparam int CW              = $clog2(QUEUE_DEPTH) + 1,
  localparam int SW              = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  BranchResult   brResult [2],
  input  logic          phtReadReq,
  output logic          fetchStall,
  output logic          phtWE,
  output PHT_IndexPath  phtWA,
  output PHT_EntryPath  phtWV,
  output logic [CW-1:0] queueCount,
  output logic          updateDropped
);

  PhtQueueEntry  head, tail, pushEntA, pushEntB;
  PhtQueueEntry  laneEnt [2];
  logic [1:0]    elig;
  logic [CW-1:0] cnt, free, slots;
  logic [SW-1:0] starve_q, starve_d;
  logic          dropped_q, dropped_d;
  logic          empty, forceWr, pop, pushA, pushB;
  logic          need0, need1, tailWe;
  PHT_EntryPath  val0, tailWv;
  logic          unused_bits;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]          = brResult[i].valid && brResult[i].isCondBr;
      laneEnt[i].phtWE = 1'b1;
      laneEnt[i].phtWA = ToPHT_Index(brResult[i].brAddr, brResult[i].globalHistory);
      laneEnt[i].phtWV = NextPhtValue(brResult[i].phtPrevValue, brResult[i].execTaken);
    end
  end

  // Arbitration: only a non-empty queue ever competes with fetch.
  always_comb begin
    empty      = (cnt == '0);
    forceWr    = (starve_q >= SW'(STARVE_LIMIT)) || (cnt >= CW'(FORCE_THRESHOLD));
    pop        = !rst && !empty && (!phtReadReq || forceWr);
    phtWE      = pop;
    fetchStall = pop && phtReadReq;
    phtWA      = pop ? head.phtWA : '0;
    phtWV      = pop ? head.phtWV : '0;
  end

`ifdef PHT_UPDATE_COALESCE_EN
  logic tailOk, m0t, m10, m1t;
  // The newest entry is a merge target unless it is the one leaving now.
  always_comb begin
    tailOk = !empty && !(cnt == CW'(1) && pop);
    m0t    = elig[0] && tailOk && (laneEnt[0].phtWA == tail.phtWA);
    m10    = elig[0] && elig[1] && (laneEnt[1].phtWA == laneEnt[0].phtWA);
    m1t    = elig[1] && !m10 && tailOk && (laneEnt[1].phtWA == tail.phtWA);
    need0  = elig[0] && !m0t;
    need1  = elig[1] && !m10 && !m1t;
    val0   = m10 ? laneEnt[1].phtWV : laneEnt[0].phtWV;
    tailWe = m0t || m1t;
    tailWv = (m10 || m1t) ? laneEnt[1].phtWV : laneEnt[0].phtWV;
  end
`else
  always_comb begin
    need0  = elig[0];
    need1  = elig[1];
    val0   = laneEnt[0].phtWV;
    tailWe = 1'b0;
    tailWv = '0;
  end
`endif

  // Pushes are compacted so the oldest surviving lane lands at the tail.
  // Slots freed by this cycle's pop are usable now.
  always_comb begin
    slots    = free + CW'(pop);
    pushEntA = laneEnt[1];
    if (need0) begin
      pushEntA       = laneEnt[0];
      pushEntA.phtWV = val0;
    end
    pushEntB  = laneEnt[1];
    pushA     = (need0 || need1) && (slots != '0);
    pushB     = need0 && need1 && (slots >= CW'(2));
    dropped_d = ((need0 || need1) && (slots == '0)) || (need0 && need1 && (slots < CW'(2)));
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop)         starve_d = '0;
    else if (starve_q != '1)  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      dropped_q <= dropped_d;
    end
  end

  pht_update_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .pushA_i  (pushA),
    .entryA_i (pushEntA),
    .pushB_i  (pushB),
    .entryB_i (pushEntB),
    .pop_i    (pop),
    .tailWe_i (tailWe),
    .tailWv_i (tailWv),
    .head_o   (head),
    .tail_o   (tail),
    .count_o  (cnt),
    .free_o   (free)
  );

  assign queueCount    = cnt;
  assign updateDropped = dropped_q;
  assign unused_bits   = ^{head.phtWE, tail};

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed self-checking bench for pht_update_scheduler. Inputs change 1 time
// unit after the rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_pht_update_scheduler;
  import pht_update_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  BranchResult  br [2];
  logic         phtReadReq;
  logic         fetchStall, phtWE, updateDropped;
  PHT_IndexPath phtWA;
  PHT_EntryPath phtWV;
  logic [5:0]   queueCount;
  int           nChecks = 0;
  int           nFail   = 0;

  always #5 clk = ~clk;

  pht_update_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .brResult      (br),
    .phtReadReq    (phtReadReq),
    .fetchStall    (fetchStall),
    .phtWE         (phtWE),
    .phtWA         (phtWA),
    .phtWV         (phtWV),
    .queueCount    (queueCount),
    .updateDropped (updateDropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    br[0] = '0;
    br[1] = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] addr, input logic [9:0] hist,
                          input logic taken, input logic [1:0] prev);
    br[l].valid         = 1'b1;
    br[l].isCondBr      = 1'b1;
    br[l].brAddr        = addr;
    br[l].globalHistory = hist;
    br[l].execTaken     = taken;
    br[l].phtPrevValue  = prev;
  endtask

  task automatic do_reset();
    clear_lanes();
    phtReadReq = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_lanes();
    phtReadReq = 1'b1;
    set_lane(0, 32'h68, 10'h0, 1'b1, 2'd1);
    rst = 1'b1;
    tick();
    #1;
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL rst_during_we: got %0b want 0", phtWE); end
    nChecks++; if (fetchStall !== 1'b0) begin nFail++; $display("FAIL rst_during_stall: got %0b want 0", fetchStall); end
    rst = 1'b0;
    clear_lanes();
    tick();
    #1;
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL rst_count: got %0d want 0", queueCount); end
    nChecks++; if (updateDropped !== 1'b0) begin nFail++; $display("FAIL rst_drop: got %0b want 0", updateDropped); end
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL rst_we: got %0b want 0", phtWE); end
    nChecks++; if (fetchStall !== 1'b0) begin nFail++; $display("FAIL rst_stall: got %0b want 0", fetchStall); end
    nChecks++; if (phtWA !== 10'h0) begin nFail++; $display("FAIL rst_wa: got %0h want 0", phtWA); end
    nChecks++; if (phtWV !== 2'd0) begin nFail++; $display("FAIL rst_wv: got %0d want 0", phtWV); end
  endtask

  task automatic test_idle_drain();
    do_reset();
    set_lane(0, 32'h68, 10'h0, 1'b1, 2'd1);   // index 0x1A, 1 -> 2
    #1;
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL idle_same_cycle_we: got %0b want 0", phtWE); end
    tick();
    clear_lanes();
    #1;
    nChecks++; if (phtWE !== 1'b1) begin nFail++; $display("FAIL idle_we: got %0b want 1", phtWE); end
    nChecks++; if (phtWV !== 2'd2) begin nFail++; $display("FAIL idle_wv: got %0d want 2", phtWV); end
    nChecks++; if (phtWA !== 10'h1A) begin nFail++; $display("FAIL idle_wa: got %0h want 1a", phtWA); end
    nChecks++; if (fetchStall !== 1'b0) begin nFail++; $display("FAIL idle_stall: got %0b want 0", fetchStall); end
    nChecks++; if (queueCount !== 6'd1) begin nFail++; $display("FAIL idle_count: got %0d want 1", queueCount); end
    // Lane 1 alone: index 0x1D, not taken 3 -> 2.
    set_lane(1, 32'h74, 10'h0, 1'b0, 2'd3);
    tick();
    clear_lanes();
    #1;
    nChecks++; if (phtWA !== 10'h1D) begin nFail++; $display("FAIL lane1_wa: got %0h want 1d", phtWA); end
    nChecks++; if (phtWV !== 2'd2) begin nFail++; $display("FAIL lane1_wv: got %0d want 2", phtWV); end
    tick();
    #1;
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL idle_empty_we: got %0b want 0", phtWE); end
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL idle_empty_count: got %0d want 0", queueCount); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_lane(0, 32'h10, 10'h0, 1'b1, 2'd3);   // index 0x4, taken 3 -> 3
    set_lane(1, 32'h20, 10'h3, 1'b0, 2'd0);   // index 0x8^0x3 = 0xB, nt 0 -> 0
    tick();
    clear_lanes();
    set_lane(0, 32'h30, 10'h0, 1'b0, 2'd2);   // index 0xC, nt 2 -> 1
    #1;
    nChecks++; if (phtWA !== 10'h4) begin nFail++; $display("FAIL sat_hi_wa: got %0h want 4", phtWA); end
    nChecks++; if (phtWV !== 2'd3) begin nFail++; $display("FAIL sat_hi_wv: got %0d want 3", phtWV); end
    nChecks++; if (queueCount !== 6'd2) begin nFail++; $display("FAIL sat_count2: got %0d want 2", queueCount); end
    tick();
    clear_lanes();
    #1;
    nChecks++; if (phtWA !== 10'hB) begin nFail++; $display("FAIL sat_lo_wa: got %0h want b", phtWA); end
    nChecks++; if (phtWV !== 2'd0) begin nFail++; $display("FAIL sat_lo_wv: got %0d want 0", phtWV); end
    nChecks++; if (queueCount !== 6'd2) begin nFail++; $display("FAIL sat_count_net: got %0d want 2", queueCount); end
    tick();
    #1;
    nChecks++; if (phtWA !== 10'hC) begin nFail++; $display("FAIL dec_wa: got %0h want c", phtWA); end
    nChecks++; if (phtWV !== 2'd1) begin nFail++; $display("FAIL dec_wv: got %0d want 1", phtWV); end
    tick();
    // Ineligible lanes: valid non-conditional, and invalid conditional.
    br[0].valid = 1'b1; br[0].isCondBr = 1'b0; br[0].brAddr = 32'h40;
    br[1].valid = 1'b0; br[1].isCondBr = 1'b1; br[1].brAddr = 32'h44;
    tick();
    clear_lanes();
    #1;
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL inelig_count: got %0d want 0", queueCount); end
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL inelig_we: got %0b want 0", phtWE); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] expCnt [6] = '{6'd2, 6'd3, 6'd4, 6'd3, 6'd2, 6'd1};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      clear_lanes();
      if (k < 3) begin
        set_lane(0, 32'((2 * k + 1) * 4), 10'h0, 1'b1, 2'd0);
        set_lane(1, 32'((2 * k + 2) * 4), 10'h0, 1'b1, 2'd0);
      end
      #1;
      if (k > 0) begin
        nChecks++; if (queueCount !== expCnt[k-1]) begin nFail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, queueCount, expCnt[k-1]); end
        nChecks++; if (phtWA !== 10'(k)) begin nFail++; $display("FAIL b2b_wa[%0d]: got %0h want %0h", k, phtWA, k); end
      end
      tick();
    end
    #1;
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL b2b_end_count: got %0d want 0", queueCount); end
  endtask

  task automatic test_starvation();
    do_reset();
    phtReadReq = 1'b1;
    set_lane(0, 32'h40, 10'h0, 1'b1, 2'd0);   // index 0x10, 0 -> 1
    tick();
    clear_lanes();
    #1;
    for (int i = 0; i < 8; i++) begin
      nChecks++; if (phtWE !== 1'b0 || fetchStall !== 1'b0) begin nFail++; $display("FAIL starve_wait[%0d]: we=%0b stall=%0b want 0/0", i, phtWE, fetchStall); end
      tick();
    end
    nChecks++; if (phtWE !== 1'b1) begin nFail++; $display("FAIL starve_we: got %0b want 1", phtWE); end
    nChecks++; if (fetchStall !== 1'b1) begin nFail++; $display("FAIL starve_stall: got %0b want 1", fetchStall); end
    nChecks++; if (phtWA !== 10'h10) begin nFail++; $display("FAIL starve_wa: got %0h want 10", phtWA); end
    nChecks++; if (phtWV !== 2'd1) begin nFail++; $display("FAIL starve_wv: got %0d want 1", phtWV); end
    // Push while the forced pop happens; the counter must restart from 0.
    set_lane(0, 32'h44, 10'h0, 1'b0, 2'd2);   // index 0x11, 2 -> 1
    tick();
    clear_lanes();
    #1;
    for (int i = 0; i < 8; i++) begin
      nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL starve2_wait[%0d]: got %0b want 0", i, phtWE); end
      tick();
    end
    nChecks++; if (phtWE !== 1'b1 || phtWA !== 10'h11) begin nFail++; $display("FAIL starve2_we: we=%0b wa=%0h want 1/11", phtWE, phtWA); end
    tick();
    #1;
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL starve_end_count: got %0d want 0", queueCount); end
    nChecks++; if (fetchStall !== 1'b0) begin nFail++; $display("FAIL empty_stall: got %0b want 0", fetchStall); end
  endtask

  // Two pushes per cycle with fetch always reading: starve-forced pop at
  // cycle 9, threshold-forced pops from 29 entries on, full at 32 and a
  // lane-1 drop at cycle 18.
  task automatic test_full_drop();
    logic [5:0] expCnt [20] = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd16, 6'd18,
                                6'd19, 6'd21, 6'd23, 6'd25, 6'd27, 6'd29, 6'd30, 6'd31, 6'd32, 6'd32};
    logic       expWe  [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic       expDrp [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int popIdx = 0;
    do_reset();
    phtReadReq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      clear_lanes();
      if (c < 19) begin
        set_lane(0, 32'(c * 8),     10'h0, 1'b1, 2'd0);
        set_lane(1, 32'(c * 8 + 4), 10'h0, 1'b1, 2'd0);
      end
      #1;
      nChecks++; if (queueCount !== expCnt[c]) begin nFail++; $display("FAIL full_count[%0d]: got %0d want %0d", c, queueCount, expCnt[c]); end
      nChecks++; if (phtWE !== expWe[c] || fetchStall !== expWe[c]) begin nFail++; $display("FAIL full_we[%0d]: we=%0b stall=%0b want %0b", c, phtWE, fetchStall, expWe[c]); end
      nChecks++; if (updateDropped !== expDrp[c]) begin nFail++; $display("FAIL full_drop[%0d]: got %0b want %0b", c, updateDropped, expDrp[c]); end
      if (expWe[c]) begin
        nChecks++; if (phtWA !== 10'(popIdx) || phtWV !== 2'd1) begin nFail++; $display("FAIL full_pop[%0d]: wa=%0h wv=%0d want %0h/1", c, phtWA, phtWV, popIdx); end
        popIdx++;
      end
      tick();
    end
    #1;
    nChecks++; if (queueCount !== 6'd31) begin nFail++; $display("FAIL full_after_count: got %0d want 31", queueCount); end
    nChecks++; if (updateDropped !== 1'b0) begin nFail++; $display("FAIL full_drop_pulse: got %0b want 0", updateDropped); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    phtReadReq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 32'(c * 8),     10'h0, 1'b0, 2'd3);
      set_lane(1, 32'(c * 8 + 4), 10'h0, 1'b0, 2'd3);
      tick();
    end
    clear_lanes();
    phtReadReq = 1'b0;
    #1;
    nChecks++; if (queueCount !== 6'd10) begin nFail++; $display("FAIL mid_count: got %0d want 10", queueCount); end
    nChecks++; if (phtWE !== 1'b1 || phtWA !== 10'h0) begin nFail++; $display("FAIL mid_first: we=%0b wa=%0h want 1/0", phtWE, phtWA); end
    tick();
    rst = 1'b1;
    #1;
    nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL mid_rst_we: got %0b want 0", phtWE); end
    tick();
    rst = 1'b0;
    #1;
    nChecks++; if (queueCount !== 6'd0) begin nFail++; $display("FAIL mid_rst_count: got %0d want 0", queueCount); end
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (phtWE !== 1'b0) begin nFail++; $display("FAIL mid_stale[%0d]: got %0b want 0", i, phtWE); end
      tick();
    end
    set_lane(0, 32'h154, 10'h0, 1'b1, 2'd2);  // index 0x55, 2 -> 3
    tick();
    clear_lanes();
    #1;
    nChecks++; if (phtWA !== 10'h55 || phtWV !== 2'd3) begin nFail++; $display("FAIL mid_fresh: wa=%0h wv=%0d want 55/3", phtWA, phtWV); end
    nChecks++; if (queueCount !== 6'd1) begin nFail++; $display("FAIL mid_fresh_count: got %0d want 1", queueCount); end
  endtask

  task automatic test_same_index();
    do_reset();
    phtReadReq = 1'b1;
    set_lane(0, 32'h68, 10'h0, 1'b1, 2'd1);   // 0x1A, 1 -> 2
    set_lane(1, 32'h68, 10'h0, 1'b1, 2'd2);   // 0x1A, 2 -> 3
    tick();
    clear_lanes();
    phtReadReq = 1'b0;
    #1;
`ifdef PHT_UPDATE_COALESCE_EN
    nChecks++; if (queueCount !== 6'd1) begin nFail++; $display("FAIL coal_count: got %0d want 1", queueCount); end
    nChecks++; if (phtWA !== 10'h1A || phtWV !== 2'd3) begin nFail++; $display("FAIL coal_val: wa=%0h wv=%0d want 1a/3", phtWA, phtWV); end
    tick();
    #1;
    nChecks++; if (queueCount !== 6'd0 || phtWE !== 1'b0) begin nFail++; $display("FAIL coal_end: count=%0d we=%0b want 0/0", queueCount, phtWE); end
`else
    nChecks++; if (queueCount !== 6'd2) begin nFail++; $display("FAIL waw_count: got %0d want 2", queueCount); end
    nChecks++; if (phtWA !== 10'h1A || phtWV !== 2'd2) begin nFail++; $display("FAIL waw_first: wa=%0h wv=%0d want 1a/2", phtWA, phtWV); end
    tick();
    #1;
    nChecks++; if (phtWA !== 10'h1A || phtWV !== 2'd3) begin nFail++; $display("FAIL waw_last: wa=%0h wv=%0d want 1a/3", phtWA, phtWV); end
    tick();
    #1;
    nChecks++; if (queueCount !== 6'd0 || phtWE !== 1'b0) begin nFail++; $display("FAIL waw_end: count=%0d we=%0b want 0/0", queueCount, phtWE); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    phtReadReq = 1'b0;
    clear_lanes();
    tick();
    tick();
    test_reset();
    test_idle_drain();
    test_saturation();
    test_back_to_back();
    test_starvation();
    test_full_drop();
    test_reset_mid_drain();
    test_same_index();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
